// File: rtl/hps_reset_sequencer_if.sv
// rtl/hps_reset_sequencer_if.sv - request/pulse signal bundle for the HPS reset sequencer
interface hps_reset_sequencer_if;
    logic       req_cold;
    logic       req_warm;
    logic       req_debug;
    logic       hps_cold_reset;
    logic       hps_warm_reset;
    logic       hps_debug_reset;
    logic       busy;
    logic [1:0] last_src;
    logic       req_dropped;

    modport master (
        output req_cold, req_warm, req_debug,
        input  hps_cold_reset, hps_warm_reset, hps_debug_reset, busy, last_src, req_dropped
    );

    modport slave (
        input  req_cold, req_warm, req_debug,
        output hps_cold_reset, hps_warm_reset, hps_debug_reset, busy, last_src, req_dropped
    );
endinterface

// File: rtl/hps_reset_sequencer.sv
// rtl/hps_reset_sequencer.sv - edge-detect, arbitrate and pulse HPS cold/warm/debug resets
// Optional cold preemption of warm/debug pulses: define HPS_RST_PREEMPT_EN.
module hps_reset_sequencer #(
    parameter int COLD_PULSE  = 6,
    parameter int WARM_PULSE  = 2,
    parameter int DEBUG_PULSE = 32,
    parameter int HOLDOFF     = 50000,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic reset,
    hps_reset_sequencer_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLDOFF} state_t;

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_COLD  = 2'd1;
    localparam logic [1:0] SRC_WARM  = 2'd2;
    localparam logic [1:0] SRC_DEBUG = 2'd3;

    localparam logic [CNT_W-1:0] COLD_LD  = CNT_W'(COLD_PULSE - 1);
    localparam logic [CNT_W-1:0] WARM_LD  = CNT_W'(WARM_PULSE - 1);
    localparam logic [CNT_W-1:0] DEBUG_LD = CNT_W'(DEBUG_PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        src_q, src_d;
    logic [1:0]        last_q, last_d;
    logic [2:0]        pend_q, pend_d;
    logic [2:0]        prev_q;
    logic [2:0]        pulse_q, pulse_d;
    logic              drop_q;
    logic [2:0]        req_w;
    logic [2:0]        edge_w;
    logic [2:0]        cand_w;

    // Bit 2 = cold, 1 = warm, 0 = debug; priority follows bit order.
    assign req_w  = {bus.req_cold, bus.req_warm, bus.req_debug};
    assign edge_w = req_w & ~prev_q;
    assign cand_w = pend_q | edge_w;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        last_d  = last_q;
        pend_d  = pend_q | edge_w;
        case (state_q)
            ST_IDLE: begin
                if (cand_w[2]) begin
                    state_d = ST_PULSE;
                    src_d   = SRC_COLD;
                    last_d  = SRC_COLD;
                    cnt_d   = COLD_LD;
                    pend_d  = 3'b000;
                end else if (cand_w[1]) begin
                    state_d   = ST_PULSE;
                    src_d     = SRC_WARM;
                    last_d    = SRC_WARM;
                    cnt_d     = WARM_LD;
                    pend_d[1] = 1'b0;
                end else if (cand_w[0]) begin
                    state_d   = ST_PULSE;
                    src_d     = SRC_DEBUG;
                    last_d    = SRC_DEBUG;
                    cnt_d     = DEBUG_LD;
                    pend_d[0] = 1'b0;
                end
            end
            ST_PULSE: begin
`ifdef HPS_RST_PREEMPT_EN
                if (edge_w[2] && (src_q != SRC_COLD)) begin
                    src_d  = SRC_COLD;
                    last_d = SRC_COLD;
                    cnt_d  = COLD_LD;
                    pend_d = 3'b000;
                end else
`endif
                if (cnt_q == '0) begin
                    if (HOLDOFF > 0) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pulse_d = 3'b000;
        if (state_d == ST_PULSE) begin
            pulse_d[2] = (src_d == SRC_COLD);
            pulse_d[1] = (src_d == SRC_WARM);
            pulse_d[0] = (src_d == SRC_DEBUG);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            src_q   <= SRC_NONE;
            last_q  <= SRC_NONE;
            pend_q  <= 3'b000;
            prev_q  <= 3'b111;
            pulse_q <= 3'b000;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            prev_q  <= req_w;
            pulse_q <= pulse_d;
            drop_q  <= |(edge_w & pend_q);
        end
    end

    assign bus.hps_cold_reset  = pulse_q[2];
    assign bus.hps_warm_reset  = pulse_q[1];
    assign bus.hps_debug_reset = pulse_q[0];
    assign bus.busy            = (state_q != ST_IDLE);
    assign bus.last_src        = last_q;
    assign bus.req_dropped     = drop_q;
endmodule

// File: tb/tb_hps_reset_sequencer.sv
// tb/tb_hps_reset_sequencer.sv - directed self-checking bench for hps_reset_sequencer
module tb_hps_reset_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   tick;
    int   n_cold, n_warm, n_debug, n_busy, n_drop;
    int   f_cold, f_warm, f_debug, f_drop;

    hps_reset_sequencer_if bus_if ();

    hps_reset_sequencer #(
        .COLD_PULSE (6),
        .WARM_PULSE (2),
        .DEBUG_PULSE(32),
        .HOLDOFF    (10),
        .CNT_W      (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        tick = 0;
        n_cold = 0; n_warm = 0; n_debug = 0; n_busy = 0; n_drop = 0;
        f_cold = 0; f_warm = 0; f_debug = 0; f_drop = 0;
    endtask

    // Advance n clocks, sampling 1 ns after each rising edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tick++;
            if (bus_if.hps_cold_reset === 1'b1) begin
                n_cold++;
                if (f_cold == 0) f_cold = tick;
            end
            if (bus_if.hps_warm_reset === 1'b1) begin
                n_warm++;
                if (f_warm == 0) f_warm = tick;
            end
            if (bus_if.hps_debug_reset === 1'b1) begin
                n_debug++;
                if (f_debug == 0) f_debug = tick;
            end
            if (bus_if.busy === 1'b1) n_busy++;
            if (bus_if.req_dropped === 1'b1) begin
                n_drop++;
                if (f_drop == 0) f_drop = tick;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr();
        reset = 1'b1;
        bus_if.req_cold  = 1'b0;
        bus_if.req_warm  = 1'b0;
        bus_if.req_debug = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cold",  32'(bus_if.hps_cold_reset), 32'd0);
        check("rst_warm",  32'(bus_if.hps_warm_reset), 32'd0);
        check("rst_debug", 32'(bus_if.hps_debug_reset), 32'd0);
        check("rst_busy",  32'(bus_if.busy), 32'd0);
        check("rst_last",  32'(bus_if.last_src), 32'd0);
        check("rst_drop",  32'(bus_if.req_dropped), 32'd0);
        reset = 1'b0;
        run(2);

        // Single warm request
        clr();
        bus_if.req_warm = 1'b1;
        run(20);
        check("warm_cnt",   32'(n_warm), 32'd2);
        check("warm_first", 32'(f_warm), 32'd1);
        check("warm_busy",  32'(n_busy), 32'd12);
        check("warm_other", 32'(n_cold + n_debug), 32'd0);
        check("warm_last",  32'(bus_if.last_src), 32'd2);
        bus_if.req_warm = 1'b0;
        run(2);

        // Simultaneous cold + debug: cold wins and subsumes debug
        clr();
        bus_if.req_cold  = 1'b1;
        bus_if.req_debug = 1'b1;
        run(40);
        check("sim_cold",   32'(n_cold), 32'd6);
        check("sim_first",  32'(f_cold), 32'd1);
        check("sim_debug",  32'(n_debug), 32'd0);
        check("sim_busy",   32'(n_busy), 32'd16);
        check("sim_last",   32'(bus_if.last_src), 32'd1);
        bus_if.req_cold  = 1'b0;
        bus_if.req_debug = 1'b0;
        run(2);

        // Queued: debug, then warm three cycles later
        clr();
        bus_if.req_debug = 1'b1;
        run(3);
        bus_if.req_warm = 1'b1;
        run(60);
        check("q_debug",      32'(n_debug), 32'd32);
        check("q_debug_first", 32'(f_debug), 32'd1);
        check("q_warm",       32'(n_warm), 32'd2);
        check("q_warm_first", 32'(f_warm), 32'd44);
        check("q_busy",       32'(n_busy), 32'd54);
        check("q_last",       32'(bus_if.last_src), 32'd2);
        bus_if.req_debug = 1'b0;
        bus_if.req_warm  = 1'b0;
        run(2);

        // Drop: two warm edges during a debug pulse
        clr();
        bus_if.req_debug = 1'b1;
        run(1);
        bus_if.req_warm = 1'b1;
        run(1);
        bus_if.req_warm = 1'b0;
        run(1);
        bus_if.req_warm = 1'b1;
        run(1);
        bus_if.req_warm  = 1'b0;
        bus_if.req_debug = 1'b0;
        run(70);
        check("drop_cnt",   32'(n_drop), 32'd1);
        check("drop_first", 32'(f_drop), 32'd4);
        check("drop_debug", 32'(n_debug), 32'd32);
        check("drop_warm",  32'(n_warm), 32'd2);
        check("drop_wfirst", 32'(f_warm), 32'd44);
        run(2);

        // Request held across reset release triggers nothing
        clr();
        bus_if.req_cold = 1'b1;
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(20);
        check("hold_cold", 32'(n_cold), 32'd0);
        check("hold_busy", 32'(n_busy), 32'd0);
        bus_if.req_cold = 1'b0;
        run(2);

        // Async reset mid cold pulse
        clr();
        bus_if.req_cold = 1'b1;
        run(3);
        check("mid_cold_pre", 32'(n_cold), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("mid_cold_low", 32'(bus_if.hps_cold_reset), 32'd0);
        check("mid_last",     32'(bus_if.last_src), 32'd0);
        check("mid_busy",     32'(bus_if.busy), 32'd0);
        run(1);
        reset = 1'b0;
        clr();
        run(20);
        check("mid_after", 32'(n_cold + n_busy), 32'd0);
        bus_if.req_cold = 1'b0;
        run(2);

        // Cold edge in cycle 5 of a debug pulse
        clr();
        bus_if.req_debug = 1'b1;
        run(5);
        check("pre_debug5", 32'(n_debug), 32'd5);
        bus_if.req_cold = 1'b1;
        clr();
        run(60);
`ifdef HPS_RST_PREEMPT_EN
        check("pre_debug",  32'(n_debug), 32'd0);
        check("pre_cold",   32'(n_cold), 32'd6);
        check("pre_cfirst", 32'(f_cold), 32'd1);
        check("pre_busy",   32'(n_busy), 32'd16);
`else
        check("pre_debug",  32'(n_debug), 32'd27);
        check("pre_cold",   32'(n_cold), 32'd6);
        check("pre_cfirst", 32'(f_cold), 32'd39);
        check("pre_busy",   32'(n_busy), 32'd53);
`endif
        check("pre_last",   32'(bus_if.last_src), 32'd1);
        bus_if.req_cold  = 1'b0;
        bus_if.req_debug = 1'b0;
        run(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hps_reset_sequencer.md
Name: hps_reset_sequencer

Overview:
- Sequences HPS reset pulses (cold, warm, debug) requested by debounced push-buttons and the source/probe reset instance.
- Performs per-source rising-edge detection, request latching, fixed-priority arbitration and pulse-width generation.
- Enforces a holdoff after each pulse.
- Sits between the request sources and the HPS reset inputs in the top-level I/O block; one instance per FPGA top.

Parameters:
- COLD_PULSE, 6: width of hps_cold_reset pulse in clk cycles; must be >= 1.
- WARM_PULSE, 2: width of hps_warm_reset pulse in clk cycles; must be >= 1.
- DEBUG_PULSE, 32: width of hps_debug_reset pulse in clk cycles; must be >= 1.
- HOLDOFF, 50000: idle cycles enforced after any pulse (1 ms at 50 MHz); 0 means no holdoff.
- CNT_W, 16: counter width; must satisfy 2^CNT_W > max(all pulse params, HOLDOFF).

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- req_cold  input  1  cold reset request level, synchronous to clk.
- req_warm  input  1  warm reset request level, synchronous to clk.
- req_debug  input  1  debug reset request level, synchronous to clk.
- hps_cold_reset  output  1  cold reset pulse, active-high.
- hps_warm_reset  output  1  warm reset pulse, active-high.
- hps_debug_reset  output  1  debug reset pulse, active-high.
- busy  output  1  high in PULSE or HOLDOFF.
- last_src  output  2  source of most recent pulse: 0 none, 1 cold, 2 warm, 3 debug.
- req_dropped  output  1  one-cycle strobe when a request edge hits an already-pending bit.

Behaviour:
- Reset (async assert, sync release): state IDLE; counter 0; pending 0; all outputs 0; last_src 0.
- Edge-history registers reset to 1, so a request held high through reset release triggers nothing.
- Inputs are already synchronous to clk; no synchronizers inside.
- Edge: edge_x = req_x & ~prev_x; prev_x <= req_x every cycle.
- Pending: pending_x is set by edge_x in any state and cleared when source x is granted.
- Drop: edge_x while pending_x is already 1 gives req_dropped = 1 for one cycle; the request is absorbed.
- Arbitration in IDLE uses (pending | edge) with priority cold > warm > debug. Only one grant per IDLE exit.
- States: IDLE, PULSE, HOLDOFF.
- IDLE -> PULSE on any candidate:
  - load counter with width-1;
  - set last_src;
  - clear granted pending bit.
  - A cold grant also clears pending warm and debug (cold subsumes them).
- PULSE: the selected hps_*_reset is 1 (registered, decoded from state plus selected source). Counter decrements each cycle.
  - Counter 0 and HOLDOFF > 0: -> HOLDOFF, counter loads HOLDOFF-1.
  - Counter 0 and HOLDOFF = 0: -> IDLE.
- HOLDOFF: all pulse outputs 0; counter decrements; at 0 -> IDLE.
- Latency: edge sampled at clock edge k while IDLE with nothing pending gives the output high from edge k to edge k+WIDTH, i.e. exactly WIDTH cycles.
- Back-to-back: a request pending at HOLDOFF exit is granted on the IDLE cycle. IDLE therefore lasts exactly 1 cycle between consecutive pulses.
- Simultaneous edges: highest priority is granted; the others stay pending (except under a cold grant, as above).
- No preemption: edges during PULSE/HOLDOFF are only latched. The exception is the optional feature below.
- busy = (state != IDLE).
- Reset asserted mid-pulse forces all outputs low immediately (async).

Optional Feature:
- Macro: HPS_RST_PREEMPT_EN.
- Defined: edge_cold during a warm or debug PULSE aborts it.
  - The next cycle the warm/debug output is 0 and hps_cold_reset goes 1 for COLD_PULSE cycles.
  - last_src = 1; pending warm/debug are cleared.
  - No holdoff is inserted between the aborted pulse and the cold pulse.
- Not defined: a cold edge during any pulse is only latched, as in the base behaviour.

Test Plan (bench params COLD_PULSE=6, WARM_PULSE=2, DEBUG_PULSE=32, HOLDOFF=10, CNT_W=8):
- Single warm: req_warm 0->1 at edge 100 -> hps_warm_reset high 2 cycles from edge 100; busy high 12 cycles; last_src=2.
- Simultaneous: req_cold and req_debug rise same edge -> cold pulse 6 cycles; debug dropped from pending (cold subsumes); no debug pulse; last_src=1.
- Queued: req_debug rises, then req_warm rises 3 cycles later -> debug 32 cycles, holdoff 10, 1 IDLE cycle, then warm 2 cycles.
- Drop: req_warm pulsed twice during a debug pulse -> req_dropped strobes once on the second edge; exactly one warm pulse follows.
- Reset: req_cold held high across reset release -> no pulse. Async reset asserted mid-cold-pulse -> hps_cold_reset 0 immediately; last_src=0.
- Preempt (HPS_RST_PREEMPT_EN defined): req_cold rises in cycle 5 of a debug pulse -> hps_debug_reset 0 next cycle, hps_cold_reset 6 cycles. Without the macro: debug completes 32 cycles, holdoff 10, then cold 6 cycles.
